// File: rtl/input_sequencer.sv
// rtl/input_sequencer.sv - debounced buttons to move/select pulses with turn timer; AUTO_PICK_EN enables auto-pick on timeout

module input_sequencer #(
  parameter int DB_CYCLES    = 16,
  parameter int TICK_CYCLES  = 50_000_000,
  parameter int TURN_SECONDS = 15
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       btn_move,
  input  logic       btn_select,
  input  logic       empty,
  input  logic       finish,
  output logic       move,
  output logic       select,
  output logic [4:0] seconds_left,
  output logic       timeout
);

  localparam int DBW = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;
  localparam int TW  = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
  localparam logic [DBW-1:0] DB_LAST   = DBW'(DB_CYCLES - 1);
  localparam logic [TW-1:0]  TICK_LAST = TW'(TICK_CYCLES - 1);
  localparam logic [4:0]     TURN_INIT = 5'(TURN_SECONDS);

`ifdef AUTO_PICK_EN
  typedef enum logic [2:0] {IDLE, AUTO_MOVE, AUTO_WAIT, AUTO_SEL, HALT} state_t;
`else
  typedef enum logic {IDLE, HALT} state_t;
`endif

  // Index 0 is the move button, index 1 the select button.
  logic [1:0]     btn_raw;
  logic [1:0]     sync1_q, sync2_q;
  logic [1:0]     db_q, db_d;
  logic [1:0]     rise;
  logic [DBW-1:0] dbc_q [2];
  logic [DBW-1:0] dbc_d [2];

  state_t         state_q, state_d;
  logic           move_q, move_d;
  logic           select_q, select_d;
  logic           timeout_q, timeout_d;
  logic           mv_pend_q, mv_pend_d;
  logic           sel_pend_q, sel_pend_d;
  logic           sel_cnt_q, sel_cnt_d;
  logic [4:0]     sec_q, sec_d;
  logic [TW-1:0]  tick_q, tick_d;

  logic           slot_free, mv_want, sel_want, tick_wrap;

`ifdef AUTO_PICK_EN
  logic [3:0]     lfsr_q, lfsr_d;
  logic [3:0]     skip_q, skip_d;
  logic [5:0]     step_q, step_d;
  logic           wait_q, wait_d;
`endif

  assign btn_raw = {btn_select, btn_move};

  // Two-flop synchronizers and debounce state for both buttons
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync1_q  <= '0;
      sync2_q  <= '0;
      db_q     <= '0;
      dbc_q[0] <= '0;
      dbc_q[1] <= '0;
    end else begin
      sync1_q  <= btn_raw;
      sync2_q  <= sync1_q;
      db_q     <= db_d;
      dbc_q[0] <= dbc_d[0];
      dbc_q[1] <= dbc_d[1];
    end
  end

  // Accept a new level after DB_CYCLES consecutive differing samples; flag accepted rising edges
  always_comb begin
    db_d     = db_q;
    rise     = '0;
    dbc_d[0] = '0;
    dbc_d[1] = '0;
    for (int i = 0; i < 2; i++) begin
      if (sync2_q[i] != db_q[i]) begin
        if (dbc_q[i] == DB_LAST) begin
          db_d[i] = sync2_q[i];
          rise[i] = sync2_q[i];
        end else begin
          dbc_d[i] = dbc_q[i] + DBW'(1);
        end
      end
    end
  end

  // A pulse may only start when neither output was high in the previous cycle.
  assign slot_free = !move_q && !select_q;
  assign mv_want   = mv_pend_q || rise[0];
  assign sel_want  = sel_pend_q || (rise[1] && !empty);
  assign tick_wrap = (tick_q == TICK_LAST);

  // Pulse arbitration, auto-pick sequencing, turn timer and halt handling
  always_comb begin
    state_d    = state_q;
    move_d     = 1'b0;
    select_d   = 1'b0;
    timeout_d  = 1'b0;
    mv_pend_d  = mv_pend_q;
    sel_pend_d = sel_pend_q;
    sel_cnt_d  = sel_cnt_q;
    sec_d      = sec_q;
    tick_d     = tick_wrap ? '0 : tick_q + TW'(1);
`ifdef AUTO_PICK_EN
    lfsr_d     = {lfsr_q[2:0], lfsr_q[3] ^ lfsr_q[2]};
    skip_d     = skip_q;
    step_d     = step_q;
    wait_d     = wait_q;
`endif

    case (state_q)
      IDLE: begin
        if (slot_free) begin
          if (mv_want) begin
            move_d     = 1'b1;
            mv_pend_d  = 1'b0;
            sel_pend_d = sel_want;
          end else if (sel_want) begin
            select_d   = 1'b1;
            sel_pend_d = 1'b0;
            mv_pend_d  = 1'b0;
          end
        end else begin
          mv_pend_d  = mv_want;
          sel_pend_d = sel_want;
        end
      end
`ifdef AUTO_PICK_EN
      AUTO_MOVE: begin
        if (slot_free) begin
          move_d  = 1'b1;
          step_d  = step_q + 6'd1;
          wait_d  = 1'b0;
          state_d = AUTO_WAIT;
        end
      end
      AUTO_WAIT: begin
        if (!wait_q) begin
          wait_d = 1'b1;
        end else if (skip_q != 4'd0 || empty) begin
          if (step_q >= 6'd32) begin
            // Searched a full lap without a usable tile: give the turn back.
            state_d   = IDLE;
            sec_d     = TURN_INIT;
            sel_cnt_d = 1'b0;
          end else begin
            state_d = AUTO_MOVE;
            if (skip_q != 4'd0) skip_d = skip_q - 4'd1;
          end
        end else begin
          state_d = AUTO_SEL;
        end
      end
      AUTO_SEL: begin
        if (slot_free) begin
          select_d = 1'b1;
          if (!sel_cnt_q) begin
            skip_d  = lfsr_q;
            step_d  = '0;
            state_d = AUTO_MOVE;
          end else begin
            state_d = IDLE;
          end
        end
      end
`endif
      HALT: ;
      default: state_d = IDLE;
    endcase

    // Button requests are discarded outside manual operation.
    if (state_q != IDLE) begin
      mv_pend_d  = 1'b0;
      sel_pend_d = 1'b0;
    end

    if (state_q == IDLE) begin
      if (tick_wrap && sec_q != 5'd0) begin
        sec_d = sec_q - 5'd1;
        if (sec_q == 5'd1) begin
          timeout_d = 1'b1;
          tick_d    = '0;
`ifdef AUTO_PICK_EN
          state_d    = AUTO_MOVE;
          move_d     = 1'b0;
          select_d   = 1'b0;
          mv_pend_d  = 1'b0;
          sel_pend_d = 1'b0;
          skip_d     = lfsr_q;
          step_d     = '0;
`endif
        end
      end
`ifndef AUTO_PICK_EN
      if (timeout_q) sec_d = TURN_INIT;
`endif
    end

    // Two issued selects make one turn.
    if (select_d) begin
      if (sel_cnt_q) begin
        sel_cnt_d = 1'b0;
        sec_d     = TURN_INIT;
      end else begin
        sel_cnt_d = 1'b1;
      end
    end
    if (timeout_d) sel_cnt_d = 1'b0;

    if (finish || state_q == HALT) begin
      state_d    = HALT;
      move_d     = 1'b0;
      select_d   = 1'b0;
      timeout_d  = 1'b0;
      mv_pend_d  = 1'b0;
      sel_pend_d = 1'b0;
      sel_cnt_d  = sel_cnt_q;
      sec_d      = sec_q;
    end
  end

  // Sequencer, timer and output registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      move_q     <= 1'b0;
      select_q   <= 1'b0;
      timeout_q  <= 1'b0;
      mv_pend_q  <= 1'b0;
      sel_pend_q <= 1'b0;
      sel_cnt_q  <= 1'b0;
      sec_q      <= TURN_INIT;
      tick_q     <= '0;
`ifdef AUTO_PICK_EN
      lfsr_q     <= 4'b1001;
      skip_q     <= '0;
      step_q     <= '0;
      wait_q     <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      move_q     <= move_d;
      select_q   <= select_d;
      timeout_q  <= timeout_d;
      mv_pend_q  <= mv_pend_d;
      sel_pend_q <= sel_pend_d;
      sel_cnt_q  <= sel_cnt_d;
      sec_q      <= sec_d;
      tick_q     <= tick_d;
`ifdef AUTO_PICK_EN
      lfsr_q     <= lfsr_d;
      skip_q     <= skip_d;
      step_q     <= step_d;
      wait_q     <= wait_d;
`endif
    end
  end

  assign move         = move_q;
  assign select       = select_q;
  assign timeout      = timeout_q;
  assign seconds_left = sec_q;

endmodule

// File: tb/tb_input_sequencer.sv
// tb/tb_input_sequencer.sv - table-driven and directed checks for input_sequencer (AUTO_PICK_EN aware)

module tb_input_sequencer;

  localparam int TS = 3;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       btn_move = 1'b0;
  logic       btn_select = 1'b0;
  logic       empty = 1'b0;
  logic       finish = 1'b0;
  logic       move, select, timeout;
  logic [4:0] seconds_left;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int n_move = 0, n_sel = 0, n_to = 0, n_viol = 0;
  int t_move = 0, t_sel = 0;
  logic prev_m = 1'b0, prev_s = 1'b0;

  typedef struct {
    logic bm;
    logic bs;
    logic emp;
    int   mv;
    int   sl;
    int   sec;
  } vec_t;

  vec_t vt [6];

  always #5 clk = ~clk;

  input_sequencer #(
    .DB_CYCLES(4),
    .TICK_CYCLES(10),
    .TURN_SECONDS(TS)
  ) dut (
    .clk(clk),
    .rst(rst),
    .btn_move(btn_move),
    .btn_select(btn_select),
    .empty(empty),
    .finish(finish),
    .move(move),
    .select(select),
    .seconds_left(seconds_left),
    .timeout(timeout)
  );

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    if (move) begin n_move++; t_move = cyc; end
    if (select) begin n_sel++; t_sel = cyc; end
    if (timeout) n_to++;
    if ((move || select) && (prev_m || prev_s || (move && select))) n_viol++;
    prev_m = move;
    prev_s = select;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick_n(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_reset();
    rst = 1'b0;
    btn_move = 1'b0;
    btn_select = 1'b0;
    finish = 1'b0;
    #1;
    check("rst_move", move, 0);
    check("rst_select", select, 0);
    check("rst_timeout", timeout, 0);
    check("rst_seconds", seconds_left, TS);
    tick_n(2);
    rst = 1'b1;
  endtask

`ifdef AUTO_PICK_EN
  task automatic run_auto(input int n_empty, output int mv, output int sl, output bit done);
    int m0, s0;
    bit seen;
    do_reset();
    empty = 1'b1;
    seen = 1'b0;
    done = 1'b0;
    for (int k = 0; k < 45; k++) begin
      if (timeout) begin seen = 1'b1; break; end
      tick_n(1);
    end
    m0 = n_move;
    s0 = n_sel;
    if (seen) begin
      for (int k = 0; k < 300; k++) begin
        tick_n(1);
        empty = ((n_move - m0) < n_empty);
        if (seconds_left == 5'(TS)) begin done = 1'b1; break; end
      end
    end
    tick_n(1);
    mv = n_move - m0;
    sl = n_sel - s0;
  endtask
`endif

  initial begin
    int m0, s0, v0, to0, t0, mv, sl;
    logic [4:0] sec0;
    bit done, seen;

    vt[0] = '{1'b1, 1'b0, 1'b0, 1, 0, 2};
    vt[1] = '{1'b0, 1'b1, 1'b0, 0, 1, 2};
    vt[2] = '{1'b1, 1'b1, 1'b0, 1, 1, 2};
    vt[3] = '{1'b0, 1'b1, 1'b1, 0, 0, 2};
    vt[4] = '{1'b1, 1'b1, 1'b1, 1, 0, 2};
    vt[5] = '{1'b0, 1'b0, 1'b0, 0, 0, 2};

    @(posedge clk);
    #1;

    for (int i = 0; i < 6; i++) begin
      do_reset();
      m0 = n_move; s0 = n_sel; v0 = n_viol;
      empty = vt[i].emp;
      btn_move = vt[i].bm;
      btn_select = vt[i].bs;
      tick_n(8);
      btn_move = 1'b0;
      btn_select = 1'b0;
      tick_n(6);
      check($sformatf("vec%0d_moves", i), n_move - m0, vt[i].mv);
      check($sformatf("vec%0d_selects", i), n_sel - s0, vt[i].sl);
      check($sformatf("vec%0d_seconds", i), seconds_left, vt[i].sec);
      check($sformatf("vec%0d_gap", i), n_viol - v0, 0);
    end
    empty = 1'b0;

    // Glitch at the start of a press: one pulse, 6 clk after the level is stable.
    do_reset();
    m0 = n_move;
    btn_move = 1'b1; tick_n(1);
    btn_move = 1'b0; tick_n(1);
    btn_move = 1'b1; t0 = cyc;
    tick_n(10);
    btn_move = 1'b0;
    tick_n(8);
    check("glitch_moves", n_move - m0, 1);
    check("glitch_latency", t_move - t0, 6);

    // Simultaneous presses: move, one low cycle, then select.
    do_reset();
    m0 = n_move; s0 = n_sel;
    btn_move = 1'b1; btn_select = 1'b1;
    tick_n(8);
    btn_move = 1'b0; btn_select = 1'b0;
    tick_n(4);
    check("both_moves", n_move - m0, 1);
    check("both_selects", n_sel - s0, 1);
    check("both_order", t_sel - t_move, 2);

    // Idle countdown and timeout.
    do_reset();
    to0 = n_to;
    tick_n(9);  check("tmr_c9", seconds_left, 3);
    tick_n(1);  check("tmr_c10", seconds_left, 2);
    tick_n(10); check("tmr_c20", seconds_left, 1);
    tick_n(9);  check("tmr_c29_to", timeout, 0);
    tick_n(1);  check("tmr_c30_sec", seconds_left, 0);
                check("tmr_c30_to", timeout, 1);
    tick_n(1);  check("tmr_c31_to", timeout, 0);
`ifdef AUTO_PICK_EN
    check("tmr_c31_sec", seconds_left, 0);
`else
    check("tmr_c31_sec", seconds_left, TS);
`endif
    check("tmr_to_count", n_to - to0, 1);

    // Second select of a turn reloads the seconds.
    do_reset();
    btn_select = 1'b1; tick_n(8);
    btn_select = 1'b0; tick_n(8);
    btn_select = 1'b1; tick_n(5);
    check("turn_c21_sec", seconds_left, 1);
    check("turn_c21_sel", select, 0);
    tick_n(1);
    check("turn_c22_sel", select, 1);
    check("turn_c22_sec", seconds_left, TS);
    tick_n(3);
    check("turn_c25_sec", seconds_left, TS);
    btn_select = 1'b0;
    tick_n(4);

    // Finish halts everything until reset.
    do_reset();
    m0 = n_move; to0 = n_to;
    finish = 1'b1;
    btn_move = 1'b1;
    tick_n(12);
    check("halt_moves", n_move - m0, 0);
    check("halt_seconds", seconds_left, TS);
    btn_move = 1'b0;
    tick_n(2);
    do_reset();
    m0 = n_move;
    btn_move = 1'b1; tick_n(8);
    btn_move = 1'b0; tick_n(4);
    check("after_halt_moves", n_move - m0, 1);

    // Reset while a pulse is high truncates it at once.
    do_reset();
    btn_move = 1'b1;
    tick_n(6);
    check("midpulse_move_hi", move, 1);
    rst = 1'b0;
    #1;
    check("midpulse_move_lo", move, 0);
    btn_move = 1'b0;
    tick_n(1);

`ifdef AUTO_PICK_EN
    v0 = n_viol;
    run_auto(3, mv, sl, done);
    check("auto_done", done, 1);
    check("auto_moves_ge3", (mv >= 3) ? 1 : 0, 1);
    check("auto_selects", sl, 2);
    check("auto_seconds", seconds_left, TS);
    run_auto(1000, mv, sl, done);
    check("giveup_done", done, 1);
    check("giveup_moves", mv, 32);
    check("giveup_selects", sl, 0);
    check("auto_gap", n_viol - v0, 0);

    // Finish while waiting for the board to settle.
    do_reset();
    empty = 1'b1;
    seen = 1'b0;
    for (int k = 0; k < 50; k++) begin
      if (move) begin seen = 1'b1; break; end
      tick_n(1);
    end
    check("autohalt_seen_move", seen, 1);
    finish = 1'b1;
    tick_n(1);
    m0 = n_move; s0 = n_sel;
    sec0 = seconds_left;
    tick_n(20);
    check("autohalt_moves", n_move - m0, 0);
    check("autohalt_selects", n_sel - s0, 0);
    check("autohalt_sec_frozen", seconds_left, sec0);
    check("autohalt_sec", seconds_left, 0);
    do_reset();
    empty = 1'b0;
    tick_n(2);
`endif

    check("gap_total", n_viol, 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/input_sequencer.md
INPUT_SEQUENCER -- requirements
Module: input_sequencer

Interface
REQ-001 Parameter DB_CYCLES, default 16: clk cycles a synchronized button level must hold stable to be accepted.
REQ-002 Parameter TICK_CYCLES, default 50_000_000: clk cycles per one-second tick.
REQ-003 Parameter TURN_SECONDS, default 15: seconds allowed per turn, range 1..31.
REQ-004 clk  in  1  single system clock; all logic on posedge.
REQ-005 rst  in  1  asynchronous active-low reset.
REQ-006 btn_move  in  1  raw cursor-advance button, active-high, asynchronous.
REQ-007 btn_select  in  1  raw select button, active-high, asynchronous.
REQ-008 empty  in  1  board flag: tile under cursor is already matched and not selectable.
REQ-009 finish  in  1  board flag: game over.
REQ-010 move  out  1  cursor-advance pulse to board.
REQ-011 select  out  1  tile-select pulse to board.
REQ-012 seconds_left  out  5  remaining turn seconds.
REQ-013 timeout  out  1  one-cycle pulse on turn expiry.

Function
REQ-014 Each button: 2-FF synchronizer, then debounce counter; level accepted after DB_CYCLES consecutive equal samples; accepted rising edge yields one request.
REQ-015 move and select are exactly 1 clk high, followed by at least 1 clk low before the next pulse on either output.
REQ-016 Move request and select request in the same cycle: move issued first, select held pending and issued on the next legal pulse slot.
REQ-017 Select request while empty=1: dropped, no pulse.
REQ-018 Requests arriving while a pulse slot is busy: at most one pending per button; further ones dropped.
REQ-019 Tick counter wraps at TICK_CYCLES-1; each wrap decrements seconds_left if nonzero.
REQ-020 seconds_left reloads to TURN_SECONDS after every second issued select pulse (one turn = two selects); select count returns to 0.
REQ-021 seconds_left transition 1->0: timeout pulses 1 clk, tick counter restarts, select count cleared, FSM leaves IDLE.
REQ-022 FSM states IDLE, AUTO_MOVE, AUTO_WAIT, AUTO_SEL, HALT.
REQ-023 IDLE: manual operation per REQ-014..018; AUTO_* states ignore button requests (discarded).
REQ-024 AUTO_MOVE: issue one move pulse, increment step count, go AUTO_WAIT.
REQ-025 AUTO_WAIT: wait 2 clk for board to settle; then, if skip count (4-bit LFSR value latched at timeout) not yet exhausted, or empty=1, return to AUTO_MOVE; else go AUTO_SEL.
REQ-026 Step count reaching 32 without a non-empty tile: go IDLE, seconds_left reloaded, no select.
REQ-027 AUTO_SEL: issue one select pulse; if it was the first select of the turn, restart search (new LFSR skip) for the second tile; after second, reload seconds_left, go IDLE.
REQ-028 LFSR: 4-bit, polynomial x^4+x^3+1, seed 4'b1001, advances every clk.
REQ-029 finish=1 in any state: go HALT next clk; no pulses; seconds_left frozen; HALT exited only by reset.

Reset
REQ-030 rst=0 asynchronously forces: move=0, select=0, timeout=0, seconds_left=TURN_SECONDS, FSM=IDLE, all counters/pending flags 0, synchronizers 0, LFSR=4'b1001.
REQ-031 Reset mid-pulse or mid-AUTO truncates immediately; first pulse after release requires fresh debounced edge.

Configuration
REQ-032 Macro AUTO_PICK_EN defined: timeout behaviour per REQ-021..027.
REQ-033 AUTO_PICK_EN undefined: timeout pulses, seconds_left reloads, select count cleared, FSM stays IDLE; no AUTO states or LFSR synthesized.

Verification (DB_CYCLES=4, TICK_CYCLES=10, TURN_SECONDS=3)
REQ-034 btn_move high 10 clk with 2-clk glitch at start -> exactly one move pulse, 1 clk wide, about 6 clk after stable high.
REQ-035 btn_move and btn_select rise same clk, empty=0 -> move pulse, 1 low clk, then select pulse.
REQ-036 btn_select with empty=1 -> no select; seconds_left unchanged.
REQ-037 No input 30 clk -> seconds_left 3,2,1,0, timeout pulse at clk 30; with AUTO_PICK_EN and empty=1 for first 3 moves -> >=3 move pulses, then select, second search, second select, seconds_left=3.
REQ-038 empty held 1 throughout timeout -> 32 move pulses, no select, FSM back to IDLE, seconds_left=3.
REQ-039 finish=1 during AUTO_WAIT -> no further pulses; seconds_left frozen; rst=0 -> all outputs at reset values the same cycle.
